ma_load_store: RTL and testbench

//  MA-stage load/store controller feeding the 4-byte-lane 1r1w data RAM, which has a 1-cycle

---
 rtl/ma_pkg.sv | 39 +++
 rtl/load_align.sv | 40 ++++
 rtl/ma_load_store.sv | 149 ++++++++++++++
 tb/tb_ma_load_store.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ma_pkg                                                           |
// | Brief    : Shared constants and M1 slot layout for the MA load/store stage  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package ma_pkg;

   localparam int ADDR_W_DEFAULT = 12;
   localparam int XLEN_DEFAULT   = 32;

   // RV32I funct3 encodings for loads and stores
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // One in-flight op between the RAM address cycle and the data cycle
   typedef struct packed {
      logic        valid;
      logic        load;
      logic [2:0]  funct3;
      logic [1:0]  lo;
      logic [4:0]  rd;
      logic        fault;
      logic [31:0] addr;
   } m1_slot_t;

   // Encodings with no RV32I load/store meaning
   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : load_align                                                       |
// | Brief    : Selects byte/half lanes from a RAM word and sign/zero-extends    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module load_align
   import ma_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  a_lo,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select followed by extension chosen by the load type
   always_comb begin
      case (a_lo)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      w_half = a_lo[1] ? rdata[31:16] : rdata[15:0];
      data   = '0;
      case (funct3)
         F3_LB:   data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   data = {{16{w_half[15]}}, w_half};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'd0, w_byte};
         F3_LHU:  data = {16'd0, w_half};
         default: data = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ma_load_store.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ma_load_store                                                    |
// | Brief    : MA-stage load/store controller with stallable M1->M2 pipe        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module ma_load_store
   import ma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int XLEN   = XLEN_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_addr,
   input  logic [XLEN-1:0]   ex_wdata,
   input  logic [4:0]        ex_rd,
   output logic [ADDR_W-1:0] ram_radr,
   input  logic [XLEN-1:0]   ram_rdata,
   output logic [ADDR_W-1:0] ram_wadr,
   output logic [XLEN-1:0]   ram_wdata,
   output logic [3:0]        ram_wen,
   output logic              wb_valid,
   input  logic              wb_stall,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              ma_fault,
   output logic [XLEN-1:0]   ma_fault_adr
);

   logic        w_accept;
   logic        w_fault;
   logic [3:0]  w_lane;
   m1_slot_t    w_m1_next;
   m1_slot_t    r_m1;
   logic        r_m1_cap;
   logic [31:0] r_m1_rdata;
   logic [31:0] w_align_src;
   logic [31:0] w_ld_data;
   logic        w_m1_ld_ok;

   // Reset low also blocks acceptance, which keeps RAM writes off during reset
   assign ex_ready = rst_n & ~wb_stall;
   assign w_accept = ex_valid & ex_ready & (ex_load | ex_store);

   // Read and write share the word address of the op being accepted
   assign ram_radr = ex_addr[ADDR_W+1:2];
   assign ram_wadr = ex_addr[ADDR_W+1:2];

   // Misalignment / illegal-encoding decode for the incoming op
   always_comb begin
      w_fault = f3_illegal(ex_funct3);
      if ((ex_funct3[1:0] == 2'b01) && ex_addr[0])
         w_fault = 1'b1;
      if ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00))
         w_fault = 1'b1;
   end

   // Store lane enables and lane-replicated write data
   always_comb begin
      w_lane    = 4'b1111;
      ram_wdata = ex_wdata;
      case (ex_funct3)
         F3_SB: begin
            w_lane    = 4'b0001 << ex_addr[1:0];
            ram_wdata = {4{ex_wdata[7:0]}};
         end
         F3_SH: begin
            w_lane    = ex_addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{ex_wdata[15:0]}};
         end
         default: begin
            w_lane    = 4'b1111;
            ram_wdata = ex_wdata;
         end
      endcase
      ram_wen = (w_accept && ex_store && !w_fault) ? w_lane : 4'b0000;
   end

   // Next M1 contents; a bubble leaves the slot fully cleared
   always_comb begin
      w_m1_next = '0;
      if (w_accept) begin
         w_m1_next.valid  = 1'b1;
         w_m1_next.load   = ex_load;
         w_m1_next.funct3 = ex_funct3;
         w_m1_next.lo     = ex_addr[1:0];
         w_m1_next.rd     = ex_rd;
         w_m1_next.fault  = w_fault;
         w_m1_next.addr   = ex_addr;
      end
   end

   // RAM output follows the moving read address, so a stalled load uses its snapshot
   assign w_align_src = r_m1_cap ? r_m1_rdata : ram_rdata;
   assign w_m1_ld_ok  = r_m1.valid & r_m1.load & ~r_m1.fault;

   load_align u_load_align (
      .rdata  (w_align_src),
      .funct3 (r_m1.funct3),
      .a_lo   (r_m1.lo),
      .data   (w_ld_data)
   );

   // M1 slot: advance when WB is free, otherwise hold and snapshot pending load data once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m1       <= '0;
         r_m1_cap   <= 1'b0;
         r_m1_rdata <= '0;
      end else if (wb_stall) begin
         if (r_m1.valid && r_m1.load && !r_m1_cap) begin
            r_m1_rdata <= ram_rdata;
            r_m1_cap   <= 1'b1;
         end
      end else begin
         r_m1     <= w_m1_next;
         r_m1_cap <= 1'b0;
      end
   end

   // M2 slot: registered result presented to WB, held while WB stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         ma_fault     <= 1'b0;
         ma_fault_adr <= '0;
      end else if (!wb_stall) begin
         wb_valid     <= r_m1.valid;
         wb_we        <= w_m1_ld_ok;
         wb_rd        <= r_m1.rd;
         wb_data      <= w_m1_ld_ok ? w_ld_data : '0;
         ma_fault     <= r_m1.valid & r_m1.fault;
         ma_fault_adr <= (r_m1.valid && r_m1.fault) ? r_m1.addr : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ma_load_store.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ma_load_store                                                 |
// | Brief    : Directed self-checking bench for ma_load_store with a RAM model  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_ma_load_store;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready, ex_load, ex_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic [11:0] ram_radr, ram_wadr;
   logic [31:0] ram_rdata, ram_wdata;
   logic [3:0]  ram_wen;
   logic        wb_valid, wb_stall, wb_we, ma_fault;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, ma_fault_adr;
   logic [39:0] slot;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ma_load_store #(.ADDR_W(12), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .ram_radr(ram_radr), .ram_rdata(ram_rdata), .ram_wadr(ram_wadr),
      .ram_wdata(ram_wdata), .ram_wen(ram_wen),
      .wb_valid(wb_valid), .wb_stall(wb_stall), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .ma_fault(ma_fault), .ma_fault_adr(ma_fault_adr)
   );

   // WB slot packed as {valid, we, fault, rd, data}
   assign slot = {wb_valid, wb_we, ma_fault, wb_rd, wb_data};

   // 1r1w byte-lane RAM with registered read address
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_radr];
   end

   task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      ex_valid = v; ex_load = ld; ex_store = st; ex_funct3 = f3;
      ex_addr = a; ex_wdata = d; ex_rd = rd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wb_stall = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, 5'd0);
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (ram_wen !== 4'b0000) begin n_fail++; $display("FAIL rst_wen got=%b exp=0000", ram_wen); end
      n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ex_ready); end
      n_checks++; if (slot !== 40'h0) begin n_fail++; $display("FAIL rst_slot got=%h exp=0", slot); end
      n_checks++; if (ma_fault_adr !== 32'h0) begin n_fail++; $display("FAIL rst_fadr got=%h exp=0", ma_fault_adr); end
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", ex_ready); end
   endtask

   task automatic test_sw_lw();
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
      #1;
      n_checks++; if (ram_wen !== 4'b1111) begin n_fail++; $display("FAIL sw_wen got=%b exp=1111", ram_wen); end
      n_checks++; if (ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got=%h exp=deadbeef", ram_wdata); end
      n_checks++; if (ram_wadr !== 12'h040) begin n_fail++; $display("FAIL sw_wadr got=%h exp=040", ram_wadr); end
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
      #1;
      n_checks++; if (ram_wen !== 4'b0000) begin n_fail++; $display("FAIL lw_wen got=%b exp=0000", ram_wen); end
      n_checks++; if (ram_radr !== 12'h040) begin n_fail++; $display("FAIL lw_radr got=%h exp=040", ram_radr); end
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b0, 1'b0, 5'd0, 32'h0}) begin n_fail++; $display("FAIL sw_slot got=%h", slot); end
      idle();
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_slot got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd1, 32'hDEADBEEF}); end
   endtask

   task automatic test_byte();
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h00000080, 5'd0);
      #1;
      n_checks++; if (ram_wen !== 4'b1000) begin n_fail++; $display("FAIL sb_wen got=%b exp=1000", ram_wen); end
      n_checks++; if (ram_wdata !== 32'h80808080) begin n_fail++; $display("FAIL sb_wdata got=%h exp=80808080", ram_wdata); end
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd5);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b0, 1'b0, 5'd0, 32'h0}) begin n_fail++; $display("FAIL sb_slot got=%h", slot); end
      drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd6);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd5, 32'hFFFFFF80}) begin n_fail++; $display("FAIL lb_slot got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd5, 32'hFFFFFF80}); end
      idle();
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd6, 32'h00000080}) begin n_fail++; $display("FAIL lbu_slot got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd6, 32'h00000080}); end
   endtask

   task automatic test_half();
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h00008001, 5'd0);
      #1;
      n_checks++; if (ram_wen !== 4'b1100) begin n_fail++; $display("FAIL sh_wen got=%b exp=1100", ram_wen); end
      n_checks++; if (ram_wdata !== 32'h80018001) begin n_fail++; $display("FAIL sh_wdata got=%h exp=80018001", ram_wdata); end
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd8);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFF8001}) begin n_fail++; $display("FAIL lh_slot got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFF8001}); end
      idle();
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd8, 32'h00008001}) begin n_fail++; $display("FAIL lhu_slot got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd8, 32'h00008001}); end
   endtask

   task automatic test_fault();
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd3);
      #1;
      n_checks++; if (ram_wen !== 4'b0000) begin n_fail++; $display("FAIL lw_mis_wen got=%b exp=0000", ram_wen); end
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h12345678, 5'd0);
      #1;
      n_checks++; if (ram_wen !== 4'b0000) begin n_fail++; $display("FAIL sw_mis_wen got=%b exp=0000", ram_wen); end
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b0, 1'b1, 5'd3, 32'h0}) begin n_fail++; $display("FAIL lw_mis_slot got=%h", slot); end
      n_checks++; if (ma_fault_adr !== 32'h101) begin n_fail++; $display("FAIL lw_mis_fadr got=%h exp=101", ma_fault_adr); end
      drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 5'd4);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b0, 1'b1, 5'd0, 32'h0}) begin n_fail++; $display("FAIL sw_mis_slot got=%h", slot); end
      n_checks++; if (ma_fault_adr !== 32'h102) begin n_fail++; $display("FAIL sw_mis_fadr got=%h exp=102", ma_fault_adr); end
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b0, 1'b1, 5'd4, 32'h0}) begin n_fail++; $display("FAIL illegal_slot got=%h", slot); end
      n_checks++; if (ma_fault_adr !== 32'h104) begin n_fail++; $display("FAIL illegal_fadr got=%h exp=104", ma_fault_adr); end
      idle();
      @(negedge clk);
      // Word 0x40 holds DEADBEEF with the SH 0x8001 in its upper half; the faulting SW must not have landed
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd7, 32'h8001BEEF}) begin n_fail++; $display("FAIL post_fault_lw got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd7, 32'h8001BEEF}); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h11111111, 5'd0);
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h304, 32'h22222222, 5'd0);
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h308, 32'h33333333, 5'd0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd1);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 5'd2);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd1, 32'h11111111}) begin n_fail++; $display("FAIL b2b_first got=%h", slot); end
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 5'd3);
      wb_stall = 1'b1;
      #1;
      n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_c0 got=%b exp=0", ex_ready); end
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd1, 32'h11111111}) begin n_fail++; $display("FAIL stall_hold_c%0d got=%h", k, slot); end
         #1;
         n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_c%0d got=%b exp=0", k, ex_ready); end
         n_checks++; if (ram_wen !== 4'b0000) begin n_fail++; $display("FAIL stall_wen_c%0d got=%b exp=0000", k, ram_wen); end
      end
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd1, 32'h11111111}) begin n_fail++; $display("FAIL stall_hold_last got=%h", slot); end
      wb_stall = 1'b0;
      #1;
      n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", ex_ready); end
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd2, 32'h22222222}) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd2, 32'h22222222}); end
      idle();
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd3, 32'h33333333}) begin n_fail++; $display("FAIL b2b_third got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd3, 32'h33333333}); end
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got=%b exp=0", wb_valid); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 5'd10);
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd9, 32'h11111111}) begin n_fail++; $display("FAIL pre_rst_slot got=%h", slot); end
      idle();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (slot !== 40'h0) begin n_fail++; $display("FAIL async_rst_slot got=%h exp=0", slot); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 5'd11);
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_stale got=%b exp=0", wb_valid); end
      @(negedge clk);
      idle();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_early got=%b exp=0", wb_valid); end
      @(negedge clk);
      n_checks++; if (slot !== {1'b1, 1'b1, 1'b0, 5'd11, 32'h33333333}) begin n_fail++; $display("FAIL post_rst_first got=%h exp=%h", slot, {1'b1, 1'b1, 1'b0, 5'd11, 32'h33333333}); end
   endtask

   initial begin
      idle();
      test_reset();
      test_sw_lw();
      test_byte();
      test_half();
      test_fault();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
